// File: rtl/one_hot_encoder_pipe_pkg.sv
// Shared types for the one-hot encoder pipeline: the per-lane encoded result
// and the index-width helper.
package cva5_types;

  localparam int MAX_IW = 16;

  typedef struct packed {
    logic [MAX_IW-1:0] index;
    logic              any;
    logic              err;
  } encoded_lane_t;

  function automatic int calc_iw(input int width);
    return (width == 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/one_hot_encoder_pipe_if.sv
// Handshake bundle for one_hot_encoder_pipe: input beat, output beat and
// error counter; slave is the encoder side, master the producer/consumer side.
interface one_hot_encoder_pipe_if
  import cva5_types::*;
#(
  parameter int C_WIDTH = 40,
  parameter int LANES   = 1,
  parameter int IW      = calc_iw(C_WIDTH)
) ();

  logic                            in_valid;
  logic                            in_ready;
  logic [LANES-1:0][C_WIDTH-1:0]   one_hot;
  logic                            out_valid;
  logic                            out_ready;
  logic [LANES-1:0][IW-1:0]        int_out;
  logic [LANES-1:0]                out_any;
  logic [LANES-1:0]                out_err;
  logic [15:0]                     err_count;

  modport slave (
    input  in_valid, one_hot, out_ready,
    output in_ready, out_valid, int_out, out_any, out_err, err_count
  );

  modport master (
    output in_valid, one_hot, out_ready,
    input  in_ready, out_valid, int_out, out_any, out_err, err_count
  );

endinterface

// File: rtl/one_hot_encoder_pipe_lane_encode.sv
// Combinational one-hot to index encoder for a single lane (OR or lowest-index
// priority). Multi-hot detection exists only when ONE_HOT_CHECK_EN is defined.
module one_hot_lane_encode
  import cva5_types::*;
#(
  parameter int C_WIDTH       = 40,
  parameter int PRIORITY_MODE = 0,
  parameter int IW            = calc_iw(C_WIDTH)
) (
  input  logic [C_WIDTH-1:0] i_one_hot,
  output logic [IW-1:0]      o_index,
  output logic               o_any,
  output logic               o_err
);

  if (PRIORITY_MODE != 0) begin : g_pri
    // Scanning downward leaves the lowest set index as the final value.
    always_comb begin
      o_index = {IW{1'b0}};
      for (int i = C_WIDTH - 1; i >= 0; i--) begin
        o_index = i_one_hot[i] ? IW'(i) : o_index;
      end
    end
  end else begin : g_or
    always_comb begin
      o_index = {IW{1'b0}};
      for (int i = 0; i < C_WIDTH; i++) begin
        o_index = o_index | (i_one_hot[i] ? IW'(i) : {IW{1'b0}});
      end
    end
  end

  assign o_any = |i_one_hot;

`ifdef ONE_HOT_CHECK_EN
  logic w_seen;
  logic w_multi;

  // A second set bit after any earlier one marks the lane multi-hot.
  always_comb begin
    w_seen  = 1'b0;
    w_multi = 1'b0;
    for (int i = 0; i < C_WIDTH; i++) begin
      w_multi = w_multi | (w_seen & i_one_hot[i]);
      w_seen  = w_seen | i_one_hot[i];
    end
  end

  assign o_err = w_multi;
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: rtl/one_hot_encoder_pipe.sv
// Multi-lane registered one-hot encoder with valid/ready and a two-entry
// (main + skid) buffer. ONE_HOT_CHECK_EN adds out_err and the saturating err_count.
module one_hot_encoder_pipe
  import cva5_types::*;
#(
  parameter int C_WIDTH       = 40,
  parameter int LANES         = 1,
  parameter int PRIORITY_MODE = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  one_hot_encoder_pipe_if.slave  bus
);

  localparam int IW = calc_iw(C_WIDTH);

  encoded_lane_t w_enc  [LANES];
  encoded_lane_t r_main [LANES];
  encoded_lane_t r_skid [LANES];
  logic          r_main_valid;
  logic          r_skid_valid;
  logic          w_accept;
  logic          w_load_main;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [IW-1:0] w_idx;
    logic          w_any;
    logic          w_err;

    one_hot_lane_encode #(
      .C_WIDTH       (C_WIDTH),
      .PRIORITY_MODE (PRIORITY_MODE),
      .IW            (IW)
    ) u_enc (
      .i_one_hot (bus.one_hot[g]),
      .o_index   (w_idx),
      .o_any     (w_any),
      .o_err     (w_err)
    );

    assign w_enc[g] = '{index: MAX_IW'(w_idx), any: w_any, err: w_err};
    assign bus.int_out[g] = r_main[g].index[IW-1:0];
    assign bus.out_any[g] = r_main[g].any;

    if (IW < MAX_IW) begin : g_pad
      logic w_unused_pad;
      assign w_unused_pad = ^r_main[g].index[MAX_IW-1:IW];
    end

`ifdef ONE_HOT_CHECK_EN
    assign bus.out_err[g] = r_main[g].err;
`else
    logic w_unused_err;
    assign w_unused_err   = r_main[g].err;
    assign bus.out_err[g] = 1'b0;
`endif
  end

  // in_ready is purely the inverted skid flag, so out_ready never reaches it.
  assign w_accept    = bus.in_valid & ~r_skid_valid;
  assign w_load_main = ~r_main_valid | bus.out_ready;

  // Main/skid storage: main refills from skid first to keep beat order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      for (int l = 0; l < LANES; l++) begin
        r_main[l] <= '0;
        r_skid[l] <= '0;
      end
    end else if (w_load_main) begin
      if (r_skid_valid) begin
        r_main       <= r_skid;
        r_main_valid <= 1'b1;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_main       <= w_enc;
        r_main_valid <= 1'b1;
      end else begin
        r_main_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid       <= w_enc;
      r_skid_valid <= 1'b1;
    end else begin
      r_skid_valid <= r_skid_valid;
    end
  end

  assign bus.out_valid = r_main_valid;
  assign bus.in_ready  = ~r_skid_valid;

`ifdef ONE_HOT_CHECK_EN
  logic        w_beat_err;
  logic [15:0] r_err_count;

  // Any lane in error makes the whole beat count once.
  always_comb begin
    w_beat_err = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      w_beat_err = w_beat_err | w_enc[l].err;
    end
  end

  // Saturating count of accepted erroneous beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_count <= 16'h0000;
    end else if (w_accept && w_beat_err && (r_err_count != 16'hFFFF)) begin
      r_err_count <= r_err_count + 16'd1;
    end else begin
      r_err_count <= r_err_count;
    end
  end

  assign bus.err_count = r_err_count;
`else
  assign bus.err_count = 16'h0000;
`endif

endmodule

// File: doc/one_hot_encoder_pipe.md
# one_hot_encoder_pipe

Registered, multi-lane one-hot-to-index encoder with a valid/ready handshake and a two-entry skid buffer, used wherever issue/writeback select vectors must be converted to indices across a pipeline boundary without a combinational ready path. Each lane encodes independently, in either OR-encode mode (input guaranteed one-hot) or lowest-index priority mode. With multi-hot checking compiled in, it flags lanes violating the one-hot contract and counts offending beats.

## Interface
- C_WIDTH, 40: bits per one-hot lane; index width IW = (C_WIDTH == 1) ? 1 : $clog2(C_WIDTH).
- LANES, 1: number of independent lanes encoded per beat.
- PRIORITY_MODE, 0: 0 = OR of indices of all set bits; 1 = index of lowest set bit.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  input beat present.
- in_ready  out  1  block can accept a beat; driven from a register only.
- one_hot  in  [LANES][C_WIDTH]  per-lane select vectors.
- out_valid  out  1  output beat present.
- out_ready  in  1  consumer accepts output beat.
- int_out  out  [LANES][IW]  per-lane encoded index.
- out_any  out  [LANES]  lane had at least one bit set.
- out_err  out  [LANES]  lane had two or more bits set (macro only).
- err_count  out  16  saturating count of accepted beats with any out_err set (macro only).

## Operation
- Transfer on each side when valid && ready in the same cycle.
- Per-lane encode: OR mode → bitwise OR of all set-bit indices; priority mode → lowest set index. All-zero lane → int_out 0, out_any 0. C_WIDTH == 1 → int_out 0, out_any = bit 0.
- Storage: main output register plus one skid register. in_ready = !skid_valid.
- Accept with main empty, or main draining this cycle, → beat loads main.
- Accept with main full and not draining → beat loads skid.
- Main drains with skid full → skid moves to main; skid empties.
- Beat order is strictly preserved; no beat is dropped or duplicated.
- Encoding happens before the main/skid registers, so both hold encoded results, not raw vectors.
- Reset, mid-operation included: main and skid valid cleared in the same cycle; any in-flight beat is discarded. Beats presented while rst is high are ignored even though in_ready reads 1.
- Reset values: out_valid 0, int_out 0, out_any 0, out_err 0, err_count 0, in_ready 1.

## Timing
- Latency: 1 cycle. A beat accepted in cycle N appears on outputs in cycle N+1.
- Throughput: 1 beat per cycle while out_ready stays high.
- Backpressure: out_ready low for k ≥ 1 cycles buffers at most 2 beats; in_ready falls the cycle after the skid fills.
- No combinational path from out_ready to in_ready, or from in_valid to out_valid.
- Outputs are stable while out_valid && !out_ready.
- Simultaneous accept and drain with skid full cannot occur, because in_ready is 0.

## Configuration
- ONE_HOT_CHECK_EN defined:
  - Per-lane popcount ≥ 2 → out_err, registered alongside int_out.
  - err_count increments once per accepted beat with any lane in error.
  - err_count saturates at 0xFFFF.
- Not defined:
  - out_err tied to 0 and err_count tied to 0.
  - No check logic is generated.
  - Encoding behaviour is unchanged.

## Structure
- Shared package cva5_types holds:
  - typedef encoded_lane_t {index, any, err}.
  - Helper function for IW.
- Sub-module one_hot_lane_encode: combinational, one instance per lane, parameters C_WIDTH and PRIORITY_MODE; outputs index, any, and err.
- The top level holds the handshake, the main/skid registers and err_count.

## Test plan
- C_WIDTH=40, LANES=2, OR mode, out_ready=1; send lane0=1<<37, lane1=1<<0 → cycle N+1 int_out {37,0}, out_any {1,1}, out_err {0,0}.
- Priority mode; lane0=0x…0A (bits 1,3) → int_out 1, out_err 1. Repeat in OR mode → int_out 3, out_err 1. With the macro, err_count increments by 1 per beat.
- Stream of 6 beats with out_ready low for cycles 2–4 → in_ready 0 after the 2nd buffered beat; all 6 beats emerge in order, none lost.
- Assert rst while main and skid are both full → next cycle out_valid 0, in_ready 1, err_count 0.
- All-zero input → int_out 0, out_any 0, out_err 0. C_WIDTH=1 with bit set → int_out 0, out_any 1.
- With the macro, force 0x10000 error beats → err_count holds 0xFFFF. Without the macro, the same multi-hot stimulus gives out_err 0 and err_count 0.
